// File: rtl/pdm_cic_multi.sv
// Multi-channel sinc^N PDM decimator; PCM is registered one clk after the emitting tick.
// The held sample waits for pcm_ready and a newer one overwrites it (sticky overrun); PDM_CIC_ROUND_EN selects rounding+saturation.
module pdm_cic_multi #(
  parameter int NUM_CH    = 2,
  parameter int CIC_ORDER = 3,
  parameter int DEC_MAX   = 64,
  parameter int DEC_SEL_W = 2,
  parameter int OUT_BITS  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            pdm_bit,
  input  logic                         pdm_valid,
  input  logic [DEC_SEL_W-1:0]         dec_sel,
  output logic [NUM_CH*OUT_BITS-1:0]   pcm_out,
  output logic                         pcm_valid,
  input  logic                         pcm_ready,
  output logic                         overrun,
  input  logic                         overrun_clr,
  output logic                         settling
);

  localparam int LOG_R = $clog2(DEC_MAX);
  localparam int W     = CIC_ORDER * LOG_R + 2;
  localparam int SH_W  = $clog2(CIC_ORDER * LOG_R + 1);
  localparam int SC_W  = $clog2(CIC_ORDER + 1);

  typedef enum logic [0:0] {ST_SETTLE, ST_RUN} state_t;

  logic [DEC_SEL_W-1:0] act_sel;
  logic [LOG_R-1:0]     dec_cnt;
  logic [LOG_R-1:0]     dec_last;
  logic [SH_W-1:0]      sh;
  logic                 ratio_chg;
  logic                 dec_tick;
  logic                 comb_en;
  logic                 emit;

  state_t               state_q, state_d;
  logic [SC_W-1:0]      settle_q, settle_d;

  logic [NUM_CH*OUT_BITS-1:0] sample_all;

  assign dec_last  = LOG_R'((DEC_MAX >> act_sel) - 1);
  assign sh        = SH_W'(CIC_ORDER * act_sel);
  assign ratio_chg = (dec_sel != act_sel);
  assign dec_tick  = pdm_valid && (dec_cnt == dec_last);
  assign comb_en   = dec_tick && !ratio_chg;
  assign settling  = (state_q == ST_SETTLE);

  // A ratio change restarts the decimation phase; the reset value tracks dec_sel too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_sel <= dec_sel;
      dec_cnt <= '0;
    end else if (ratio_chg) begin
      act_sel <= dec_sel;
      dec_cnt <= '0;
    end else if (pdm_valid) begin
      dec_cnt <= (dec_cnt == dec_last) ? '0 : dec_cnt + LOG_R'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_SETTLE;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    emit     = 1'b0;
    if (ratio_chg) begin
      state_d  = ST_SETTLE;
      settle_d = '0;
    end else if (dec_tick) begin
      case (state_q)
        ST_SETTLE: begin
          if (settle_q == SC_W'(CIC_ORDER - 1)) begin
            state_d  = ST_RUN;
            settle_d = '0;
          end else begin
            settle_d = settle_q + SC_W'(1);
          end
        end
        ST_RUN:  emit = 1'b1;
        default: state_d = ST_SETTLE;
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [W-1:0]  x_in;
    logic signed [W-1:0]  integ_q [CIC_ORDER];
    logic signed [W-1:0]  integ_d [CIC_ORDER];
    logic signed [W-1:0]  dly_q   [CIC_ORDER];
    logic signed [W-1:0]  comb_v  [CIC_ORDER+1];
    logic signed [W-1:0]  scaled;
    logic [OUT_BITS-1:0]  sample;

    // 1 -> +1, 0 -> -1 in two's complement
    assign x_in = {{(W-1){~pdm_bit[c]}}, 1'b1};

    for (genvar k = 0; k < CIC_ORDER; k++) begin : g_int
      if (k == 0) begin : g_first
        assign integ_d[k] = integ_q[k] + x_in;
      end else begin : g_rest
        assign integ_d[k] = integ_q[k] + integ_d[k-1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < CIC_ORDER; k++) integ_q[k] <= '0;
      end else if (pdm_valid) begin
        for (int k = 0; k < CIC_ORDER; k++) integ_q[k] <= integ_d[k];
      end
    end

    // Combs see the integrator value that already includes the ticking sample.
    assign comb_v[0] = integ_d[CIC_ORDER-1];
    for (genvar k = 0; k < CIC_ORDER; k++) begin : g_comb
      assign comb_v[k+1] = comb_v[k] - dly_q[k];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < CIC_ORDER; k++) dly_q[k] <= '0;
      end else if (ratio_chg) begin
        for (int k = 0; k < CIC_ORDER; k++) dly_q[k] <= '0;
      end else if (comb_en) begin
        for (int k = 0; k < CIC_ORDER; k++) dly_q[k] <= comb_v[k];
      end
    end

    assign scaled = comb_v[CIC_ORDER] <<< sh;

`ifdef PDM_CIC_ROUND_EN
    localparam logic signed [W:0] RND_V = (W+1)'(1) <<< (W - OUT_BITS - 1);
    logic signed [W:0] rnd;
    logic              pos_ovf;

    assign rnd     = {scaled[W-1], scaled} + RND_V;
    assign pos_ovf = !rnd[W] && rnd[W-1];
    assign sample  = pos_ovf ? {1'b0, {(OUT_BITS-1){1'b1}}}
                             : OUT_BITS'(rnd >>> (W - OUT_BITS));
`else
    assign sample  = OUT_BITS'(scaled >>> (W - OUT_BITS));
`endif

    assign sample_all[c*OUT_BITS +: OUT_BITS] = sample;
  end

  // Acceptance and a fresh emit in the same cycle is a clean hand-off, not an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (emit) begin
        pcm_out   <= sample_all;
        pcm_valid <= 1'b1;
      end else if (pcm_ready) begin
        pcm_valid <= 1'b0;
      end
      if (overrun_clr) begin
        overrun <= 1'b0;
      end else if (emit && pcm_valid && !pcm_ready) begin
        overrun <= 1'b1;
      end
    end
  end

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    pcm_valid && !pcm_ready && !emit |=> pcm_valid && $stable(pcm_out));

  a_cnt_range: assert property (@(posedge clk) disable iff (rst)
    dec_cnt <= dec_last);

endmodule
